// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster pixel stream into stride-1, unpadded SxS
// sliding windows for convUnit. S-1 line buffers hold the previous rows, and
// an SxS register holds the window itself. A window is flagged valid only once
// the counters show that every one of its rows and columns belongs to the
// current frame.
module conv_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int S          = 5,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         win_valid,
  output logic [S*S*DATA_WIDTH-1:0]    win_data,
  input  logic                         win_ready,
  output logic                         frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(S - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(S - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] lb      [S-1][IMG_W];
  logic [DATA_WIDTH-1:0] win     [S][S];
  logic [DATA_WIDTH-1:0] new_col [S];
  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  qual;

  // Stall the input only while a finished window is still waiting to be taken.
  assign in_ready = !(win_valid && !win_ready);
  assign accept   = in_valid && in_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign qual     = (row >= ROW_WIN) && (col >= COL_WIN);

  // The incoming right-hand column, oldest row at the top. It reads the line
  // buffers before this cycle's update.
  genvar gr, gc;
  generate
    for (gr = 0; gr < S - 1; gr++) begin : g_newcol
      assign new_col[gr] = lb[S-2-gr][col];
    end
  endgenerate
  assign new_col[S-1] = in_data;

  // Flatten the window with the top-left element in the MSBs.
  generate
    for (gr = 0; gr < S; gr++) begin : g_row
      for (gc = 0; gc < S; gc++) begin : g_col
        assign win_data[((S*S-1)-(gr*S+gc))*DATA_WIDTH +: DATA_WIDTH] = win[gr][gc];
      end
    end
  endgenerate

  // Track the raster position, the window handshake and the end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (accept && qual)
        win_valid <= 1'b1;
      else if (win_ready)
        win_valid <= 1'b0;
    end
  end

  // Push each accepted pixel down its column of line buffers. These entries
  // need no reset, because qual keeps stale contents out of any valid window.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = S - 2; k >= 1; k--)
        lb[k][col] <= lb[k-1][col];
      lb[0][col] <= in_data;
    end
  end

  // Slide the window left by one column and load the new right column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < S; r++)
        for (int c = 0; c < S; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < S; r++) begin
        for (int c = 0; c < S - 1; c++)
          win[r][c] <= win[r][c+1];
        win[r][S-1] <= new_col[r];
      end
    end
  end

endmodule
